// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three sides of the shared memory port: the instruction-fetch
//   requester, the MEM-stage data requester and the single memory port.
//   master : arbiter view (takes requests and memory responses, drives
//            completions, stalls and the memory command)
//   slave  : environment view (requesters plus memory)
// Parameters: ADDR_W address width, DATA_W data width.

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  // data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;

  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_done, if_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_done, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_done, if_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_done, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Serializes instruction fetches and data accesses onto one single-ported
//   memory with a variable-latency req/ack handshake. Data wins collisions,
//   except that a waiting fetch is granted after STARVE_LIMIT consecutive data
//   grants. Every access costs at least three cycles: grant (IDLE), one or more
//   BUSY cycles until mem_ack, then a RESP cycle carrying the done pulse.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mem_port_arbiter_if.master (requesters, stalls, memory port)
//
// state  | meaning
// IDLE   | no access in flight; grant a pending request at end of cycle
// BUSY_I | fetch access on the memory port, waiting for mem_ack
// BUSY_D | data access on the memory port, waiting for mem_ack
// RESP   | done pulse to the granted requester; no new grant this cycle

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [CNT_W-1:0]  starve_cnt;
  logic              owner_d;      // last grant went to the data requester
  logic              grant_i;
  logic              grant_d;
  logic              fetch_due;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // Next-state and grant decision. Grants only come from registered state and
  // the request inputs; the mem_* outputs are all registered or state-decoded,
  // so no combinational path exists from a request to the memory port.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    fetch_due = bus.if_req && (starve_cnt == CNT_MAX);
    case (state)
      IDLE: begin
        if (bus.d_req && !fetch_due) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (bus.if_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.mem_ack) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latched command, starvation counter and captured read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= '0;
      owner_d     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (grant_d) begin
        owner_d     <= 1'b1;
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        // Counts data grants that overtook a waiting fetch; a data grant with
        // no fetch waiting means nobody is being starved.
        if (bus.if_req) begin
          if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
        end else begin
          starve_cnt <= '0;
        end
      end

      if (grant_i) begin
        owner_d    <= 1'b0;
        mem_we_q   <= 1'b0;
        mem_addr_q <= bus.if_addr;
        starve_cnt <= '0;
      end

      if ((state == BUSY_I) && bus.mem_ack) begin
        if_rdata_q <= bus.mem_rdata;
      end

      // Writes leave the data read register untouched.
      if ((state == BUSY_D) && bus.mem_ack && !mem_we_q) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = (state == BUSY_I) || (state == BUSY_D);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.if_done   = (state == RESP) && !owner_d;
  assign bus.d_done    = (state == RESP) && owner_d;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  // Stalls drop in the done cycle so the pipeline register captures at its end.
  assign bus.if_stall  = bus.if_req && !bus.if_done;
  assign bus.d_stall   = bus.d_req && !bus.d_done;

endmodule
